trace_checker: RTL and testbench

TRACE_CHECKER -- requirements
Module: trace_checker

---
 rtl/trace_pkg.sv | 14 +
 rtl/trace_fifo.sv | 49 ++++
 rtl/trace_checker.sv | 142 ++++++++++++++
 tb/tb_trace_checker.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the trace checker: run-state encoding and the
// width and saturation value of the mismatch counter.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int              ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/trace_fifo.sv
// Expected-vector store: a DEPTH-entry FIFO with occupancy count 0..DEPTH.
// The head entry is read combinationally so a sample can be checked in the cycle it arrives.
module trace_fifo #(
    parameter int  WIDTH = 99,
    parameter int  DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/trace_checker.sv
// Compares observed datapath samples against a preloaded list of masked expected
// vectors and reports pass/fail, mismatch count, first failure and timeout.
module trace_checker
    import trace_pkg::*;
#(
    parameter int NCH          = 3,
    parameter int W            = 32,
    parameter int DEPTH        = 64,
    parameter int STOP_ON_FAIL = 0,
    parameter int TIMEOUT      = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [NCH*W-1:0]         load_data,
    input  logic [NCH-1:0]           load_mask,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     obs_valid,
    input  logic [NCH*W-1:0]         obs_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [ERR_W-1:0]         err_count,
    output logic [$clog2(DEPTH):0]   first_err_idx,
    output logic [NCH-1:0]           first_err_chan
);

    localparam int IW = $clog2(DEPTH) + 1;
    localparam int FW = NCH*W + NCH;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e           state_q;
    logic [TW-1:0]    idle_cnt_q;
    logic [IW-1:0]    sample_idx_q;
    logic [ERR_W-1:0] err_count_q;
    logic [IW-1:0]    first_err_idx_q;
    logic [NCH-1:0]   first_err_chan_q;
    logic             pass_q;
    logic             timeout_q;

    logic             push;
    logic             pop;
    logic             stop_flush;
    logic [FW-1:0]    head;
    logic [IW-1:0]    fifo_count;
    logic [NCH-1:0]   differ;

    assign load_ready = (state_q == ST_IDLE) && (fifo_count < IW'(DEPTH));
    assign push       = load_valid && load_ready && !clear;
    assign pop        = (state_q == ST_RUN) && obs_valid && !clear;
    // An early stop throws away whatever expected entries are still queued.
    assign stop_flush = (STOP_ON_FAIL != 0) && pop && (|differ);

    trace_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (reset),
        .flush     (clear || stop_flush),
        .push      (push),
        .push_data ({load_mask, load_data}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cmp
            assign differ[gi] = head[NCH*W + gi] && (obs_data[gi*W +: W] != head[gi*W +: W]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q          <= ST_IDLE;
            idle_cnt_q       <= '0;
            sample_idx_q     <= '0;
            err_count_q      <= '0;
            first_err_idx_q  <= '0;
            first_err_chan_q <= '0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    idle_cnt_q   <= '0;
                    sample_idx_q <= '0;
                    // A load in the start cycle is part of this run.
                    if (start) begin
                        if (fifo_count != '0 || push) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_DONE;
                            pass_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (obs_valid) begin
                        idle_cnt_q   <= '0;
                        sample_idx_q <= sample_idx_q + IW'(1);
                        if (|differ) begin
                            if (err_count_q != ERR_MAX) begin
                                err_count_q <= err_count_q + ERR_W'(1);
                            end
                            if (err_count_q == '0) begin
                                first_err_idx_q  <= sample_idx_q;
                                first_err_chan_q <= differ;
                            end
                        end
                        if (fifo_count == IW'(1) || stop_flush) begin
                            state_q <= ST_DONE;
                            pass_q  <= (err_count_q == '0) && !(|differ);
                        end
                    end else if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
                        state_q   <= ST_DONE;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + TW'(1);
                    end
                end
                ST_DONE: begin
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_count_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_chan = first_err_chan_q;

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: directed scenarios plus randomized runs scored against
// a queue-based model of the expected-vector list.
module tb_trace_checker;

    localparam int NCH   = 3;
    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int TMO   = 8;
    localparam int IW    = 4;

    typedef struct packed {
        logic [NCH*W-1:0] d;
        logic [NCH-1:0]   m;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, load_valid, start, clear, obs_valid;
    logic [NCH*W-1:0] load_data, obs_data;
    logic [NCH-1:0]   load_mask;

    logic             load_ready_a, busy_a, done_a, pass_a, timeout_a;
    logic [15:0]      err_a;
    logic [IW-1:0]    fidx_a;
    logic [NCH-1:0]   fchan_a;
    logic             load_ready_b, busy_b, done_b, pass_b, timeout_b;
    logic [15:0]      err_b;
    logic [IW-1:0]    fidx_b;
    logic [NCH-1:0]   fchan_b;

    trace_checker #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .STOP_ON_FAIL(0), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_a),
        .load_data(load_data), .load_mask(load_mask), .start(start), .clear(clear),
        .obs_valid(obs_valid), .obs_data(obs_data), .busy(busy_a), .done(done_a),
        .pass(pass_a), .timeout(timeout_a), .err_count(err_a),
        .first_err_idx(fidx_a), .first_err_chan(fchan_a)
    );

    trace_checker #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .STOP_ON_FAIL(1), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_b),
        .load_data(load_data), .load_mask(load_mask), .start(start), .clear(clear),
        .obs_valid(obs_valid), .obs_data(obs_data), .busy(busy_b), .done(done_b),
        .pass(pass_b), .timeout(timeout_b), .err_count(err_b),
        .first_err_idx(fidx_b), .first_err_chan(fchan_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    vec_t           exp_q[$];
    int             m_err;
    int             m_idx;
    int             m_fidx;
    logic [NCH-1:0] m_fchan;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*W-1:0] mk(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic [31:0] alu);
        return {alu, ins, pc};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_err   = 0;
        m_idx   = 0;
        m_fidx  = 0;
        m_fchan = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset();
    endtask

    task automatic load_vec(input logic [NCH*W-1:0] d, input logic [NCH-1:0] m, input bit with_start);
        vec_t v;
        check("load_ready", load_ready_a, 1);
        load_valid = 1'b1;
        load_data  = d;
        load_mask  = m;
        start      = with_start;
        tick();
        load_valid = 1'b0;
        start      = 1'b0;
        v.d = d;
        v.m = m;
        exp_q.push_back(v);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Model: one observed sample consumes the oldest expected vector.
    task automatic sample(input logic [NCH*W-1:0] d);
        vec_t           e;
        logic [NCH-1:0] dif;
        e   = exp_q.pop_front();
        dif = '0;
        for (int k = 0; k < NCH; k++) begin
            if (e.m[k] && (d[k*W +: W] != e.d[k*W +: W])) dif[k] = 1'b1;
        end
        if (dif != '0) begin
            if (m_err == 0) begin
                m_fidx  = m_idx;
                m_fchan = dif;
            end
            m_err++;
        end
        m_idx++;
        obs_valid = 1'b1;
        obs_data  = d;
        tick();
        obs_valid = 1'b0;
    endtask

    task automatic check_result(input string tag);
        check({tag, ":done"},    done_a, 1);
        check({tag, ":busy"},    busy_a, 0);
        check({tag, ":pass"},    pass_a, (m_err == 0) ? 1 : 0);
        check({tag, ":timeout"}, timeout_a, 0);
        check({tag, ":err"},     err_a, 64'(m_err));
        check({tag, ":fidx"},    fidx_a, 64'(m_fidx));
        check({tag, ":fchan"},   fchan_a, 64'(m_fchan));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int             cycles;
        logic [NCH*W-1:0] d;
        logic [31:0]    x;
        int             n;

        reset = 1'b1; load_valid = 1'b0; start = 1'b0; clear = 1'b0; obs_valid = 1'b0;
        load_data = '0; load_mask = '0; obs_data = '0;
        model_reset();
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst:load_ready", load_ready_a, 1);
        check("rst:busy", busy_a, 0);
        check("rst:done", done_a, 0);
        check("rst:pass", pass_a, 0);
        check("rst:timeout", timeout_a, 0);
        check("rst:err", err_a, 0);
        check("rst:fidx", fidx_a, 0);
        check("rst:fchan", fchan_a, 0);

        // Three matching samples
        load_vec(mk(0, 32'h13, 32'h3), 3'b111, 0);
        load_vec(mk(4, 32'h93, 32'h7), 3'b111, 0);
        load_vec(mk(8, 32'h33, 32'hA), 3'b111, 0);
        do_start();
        check("match:busy", busy_a, 1);
        sample(mk(0, 32'h13, 32'h3));
        sample(mk(4, 32'h93, 32'h7));
        check("match:busy_mid", busy_a, 1);
        sample(mk(8, 32'h33, 32'hA));
        check_result("match");
        check("match:pass_const", pass_a, 1);

        // ALU mismatch on sample 1
        do_clear();
        check("clear:done", done_a, 0);
        load_vec(mk(0, 32'h13, 32'h3), 3'b111, 0);
        load_vec(mk(4, 32'h93, 32'h7), 3'b111, 0);
        load_vec(mk(8, 32'h33, 32'hA), 3'b111, 0);
        do_start();
        sample(mk(0, 32'h13, 32'h3));
        sample(mk(4, 32'h93, 32'h5));
        sample(mk(8, 32'h33, 32'hA));
        check_result("alu");
        check("alu:err_const", err_a, 1);
        check("alu:fidx_const", fidx_a, 1);
        check("alu:fchan_const", fchan_a, 3'b100);

        // Stop-on-fail instance: mismatch on sample 0 of 4
        do_clear();
        for (int i = 0; i < 4; i++) load_vec(mk(32'(i*4), 32'h1, 32'h2), 3'b111, 0);
        do_start();
        check("stop:busy", busy_b, 1);
        sample(mk(0, 32'h1, 32'h99));
        check("stop:done", done_b, 1);
        check("stop:err", err_b, 1);
        check("stop:fidx", fidx_b, 0);
        check("stop:fchan", fchan_b, 3'b100);
        check("stop:pass", pass_b, 0);
        sample(mk(4, 32'h1, 32'h77));
        sample(mk(8, 32'h1, 32'h77));
        check("stop:err_hold", err_b, 1);
        check("stop:done_hold", done_b, 1);

        // Fill to DEPTH, extra load refused, then a full matching run
        do_clear();
        for (int i = 0; i < DEPTH; i++) load_vec(mk(32'(i), $urandom, $urandom), 3'b111, 0);
        check("full:load_ready", load_ready_a, 0);
        load_valid = 1'b1;
        load_data  = mk(32'hDEAD, 0, 0);
        tick();
        load_valid = 1'b0;
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            check("full:busy", busy_a, 1);
            sample(exp_q[0].d);
        end
        check_result("full");

        // Timeout with 2 vectors and no samples
        do_clear();
        load_vec(mk(0, 1, 2), 3'b111, 0);
        load_vec(mk(4, 1, 2), 3'b111, 0);
        do_start();
        check("tmo:busy", busy_a, 1);
        cycles = 0;
        while (!done_a && cycles < 50) begin
            tick();
            cycles++;
        end
        check("tmo:cycles", 64'(cycles), TMO);
        check("tmo:done", done_a, 1);
        check("tmo:timeout", timeout_a, 1);
        check("tmo:pass", pass_a, 0);

        // Reset mid-run, then an empty start
        do_clear();
        load_vec(mk(0, 1, 2), 3'b111, 0);
        load_vec(mk(4, 1, 2), 3'b111, 0);
        do_start();
        sample(mk(1, 1, 2));
        check("rmid:err", err_a, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("rmid:load_ready", load_ready_a, 1);
        check("rmid:busy", busy_a, 0);
        check("rmid:done", done_a, 0);
        check("rmid:err", err_a, 0);
        check("rmid:fidx", fidx_a, 0);
        check("rmid:fchan", fchan_a, 0);
        do_start();
        check("rmid:done2", done_a, 1);
        check("rmid:pass2", pass_a, 1);
        check("rmid:timeout2", timeout_a, 0);

        // Randomized runs: masks, corruptions, gaps, stray idle samples, load+start
        for (int r = 0; r < 8; r++) begin
            do_clear();
            obs_valid = 1'b1;
            obs_data  = {$urandom, $urandom, $urandom};
            tick();
            obs_valid = 1'b0;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                load_vec({$urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)),
                         (r % 2 == 1) && (i == n - 1));
            end
            if (r % 2 == 0) do_start();
            check("rnd:busy", busy_a, 1);
            for (int i = 0; i < n; i++) begin
                for (int g = $urandom_range(0, 3); g > 0; g--) begin
                    obs_data = {$urandom, $urandom, $urandom};
                    tick();
                end
                d = exp_q[0].d;
                for (int k = 0; k < NCH; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        x = $urandom;
                        if (x == 0) x = 32'h1;
                        d[k*W +: W] = d[k*W +: W] ^ x;
                    end
                end
                sample(d);
            end
            check_result($sformatf("rnd%0d", r));
            obs_valid = 1'b1;
            obs_data  = {$urandom, $urandom, $urandom};
            tick();
            obs_valid = 1'b0;
            check("rnd:err_hold", err_a, 64'(m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
